// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Purpose:
//   Arbitrates a single-port data memory between the CPU M-stage and an
//   external (loader/debug) requester. At most one access issues per cycle.
//   The issue path is combinational from the requests and registered state.
//   Read data returns one cycle after issue and is steered to the port that
//   issued the read.
//
// Configuration:
//   ARB_RR_EN  - when defined, conflicts are resolved round-robin, with a
//                starvation guard that forces a CPU win. When undefined, the
//                CPU always wins conflicts.
//
// Ports:
//   CLK, RSTN                           clock, synchronous active-low reset
//   CPU_REQ/DRW/ADDR/WDATA              CPU access request (DRW: 1 = write)
//   CPU_STALL                           CPU request not served this cycle
//   CPU_RVALID/RDATA                    CPU read return (RDATA holds)
//   EXT_REQ/DRW/ADDR/WDATA              external access request
//   EXT_GNT                             external access issued this cycle
//   EXT_RVALID/RDATA                    external read return (RDATA holds)
//   MEM_CSN/WEN (active-low)            memory select / write enable
//   MEM_ADDR/WDATA, MEM_RDATA           memory bus; RDATA valid 1 cycle after
//                                       a read issue
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int unsigned AW         = 12,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          CPU_REQ,
    input  logic          CPU_DRW,
    input  logic [AW-1:0] CPU_ADDR,
    input  logic [31:0]   CPU_WDATA,
    output logic          CPU_STALL,
    output logic          CPU_RVALID,
    output logic [31:0]   CPU_RDATA,
    input  logic          EXT_REQ,
    input  logic          EXT_DRW,
    input  logic [AW-1:0] EXT_ADDR,
    input  logic [31:0]   EXT_WDATA,
    output logic          EXT_GNT,
    output logic          EXT_RVALID,
    output logic [31:0]   EXT_RDATA,
    output logic          MEM_CSN,
    output logic          MEM_WEN,
    output logic [AW-1:0] MEM_ADDR,
    output logic [31:0]   MEM_WDATA,
    input  logic [31:0]   MEM_RDATA
);

    localparam int unsigned CntW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CPU,
        S_EXT
    } owner_e;

    owner_e            state_q, state_d;
    logic [CntW-1:0]   starve_cnt_q, starve_cnt_d;
    logic              rd_pend_q, rd_pend_d;
    logic [31:0]       cpu_rdata_q, cpu_rdata_d;
    logic [31:0]       ext_rdata_q, ext_rdata_d;

    logic              cpu_pref;
    logic              starve_hit;
    logic              cpu_win;
    logic              ext_win;
    logic              cpu_rvalid;
    logic              ext_rvalid;

`ifdef ARB_RR_EN
    // 1 = EXT won the most recent conflict, so the CPU is preferred next.
    logic              last_ext_q, last_ext_d;
`endif

    // -------------------------------------------------------------------------
    // Arbitration and issue
    // -------------------------------------------------------------------------
    always_comb begin
`ifdef ARB_RR_EN
        cpu_pref = last_ext_q;
`else
        cpu_pref = 1'b1;
`endif
        starve_hit = (starve_cnt_q == CntW'(STARVE_MAX));

        // Reset gates the issue path so nothing reaches the memory.
        cpu_win = RSTN & CPU_REQ & (~EXT_REQ | cpu_pref | starve_hit);
        ext_win = RSTN & EXT_REQ & ~cpu_win;

        CPU_STALL = RSTN & CPU_REQ & ~cpu_win;
        EXT_GNT   = ext_win;

        MEM_CSN   = ~(cpu_win | ext_win);
        MEM_WEN   = ~((cpu_win & CPU_DRW) | (ext_win & EXT_DRW));
        MEM_ADDR  = '0;
        MEM_WDATA = '0;
        if (cpu_win) begin
            MEM_ADDR  = CPU_ADDR;
            MEM_WDATA = CPU_WDATA;
        end else if (ext_win) begin
            MEM_ADDR  = EXT_ADDR;
            MEM_WDATA = EXT_WDATA;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = S_IDLE;
        if (cpu_win) begin
            state_d = S_CPU;
        end else if (ext_win) begin
            state_d = S_EXT;
        end

        starve_cnt_d = starve_cnt_q;
        if (!CPU_REQ || cpu_win) begin
            starve_cnt_d = '0;
        end else if (!starve_hit) begin
            starve_cnt_d = starve_cnt_q + CntW'(1);
        end

        rd_pend_d = (cpu_win & ~CPU_DRW) | (ext_win & ~EXT_DRW);

`ifdef ARB_RR_EN
        last_ext_d = last_ext_q;
        if (RSTN && CPU_REQ && EXT_REQ) begin
            last_ext_d = ext_win;
        end
`endif
    end

    // -------------------------------------------------------------------------
    // Read return: the owner of last cycle's read gets this cycle's MEM_RDATA.
    // Data is bypassed on the return cycle and held in a register afterwards.
    // -------------------------------------------------------------------------
    always_comb begin
        cpu_rvalid = RSTN & rd_pend_q & (state_q == S_CPU);
        ext_rvalid = RSTN & rd_pend_q & (state_q == S_EXT);

        cpu_rdata_d = cpu_rvalid ? MEM_RDATA : cpu_rdata_q;
        ext_rdata_d = ext_rvalid ? MEM_RDATA : ext_rdata_q;

        CPU_RVALID = cpu_rvalid;
        EXT_RVALID = ext_rvalid;
        CPU_RDATA  = cpu_rdata_d;
        EXT_RDATA  = ext_rdata_d;
    end

    // -------------------------------------------------------------------------
    // State registers (synchronous active-low reset)
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q      <= S_IDLE;
            starve_cnt_q <= '0;
            rd_pend_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            ext_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            rd_pend_q    <= rd_pend_d;
            cpu_rdata_q  <= cpu_rdata_d;
            ext_rdata_q  <= ext_rdata_d;
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            last_ext_q <= 1'b1;
        end else begin
            last_ext_q <= last_ext_d;
        end
    end
`endif

endmodule
